// File: rtl/circuito_exp4_pkg.sv
// Shared definitions for the memory-sequence game: data width, FSM state
// encodings (which double as the db_estado hex digit) and the sequence ROM.
package circuito_exp4_pkg;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARACAO    = 4'h1,
    ESPERA_JOGADA = 4'h2,
    REGISTRA      = 4'h4,
    COMPARA       = 4'h5,
    PROXIMO       = 4'h6,
    FIM_ACERTO    = 4'hA,
    FIM_ERRO      = 4'hE
  } estado_t;

  // Address F occupies the most significant nibble, address 0 the least.
  localparam logic [16*DATA_W-1:0] ROM_CONTENTS = 64'h4188_4422_1124_8421;

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] addr);
    return ROM_CONTENTS[int'(addr)*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/circuito_exp4_hexa7seg.sv
// 4-bit to 7-segment decoder; active-low segments, bit order gfedcba.
module hexa7seg (
  input  logic [3:0] hexa,
  output logic [6:0] display
);

  always_comb begin
    case (hexa)
      4'h0:    display = 7'h40;
      4'h1:    display = 7'h79;
      4'h2:    display = 7'h24;
      4'h3:    display = 7'h30;
      4'h4:    display = 7'h19;
      4'h5:    display = 7'h12;
      4'h6:    display = 7'h02;
      4'h7:    display = 7'h78;
      4'h8:    display = 7'h00;
      4'h9:    display = 7'h10;
      4'hA:    display = 7'h08;
      4'hB:    display = 7'h03;
      4'hC:    display = 7'h46;
      4'hD:    display = 7'h21;
      4'hE:    display = 7'h06;
      default: display = 7'h0E;
    endcase
  end

endmodule

// File: rtl/circuito_exp4.sv
// Memory-sequence game: the player repeats the 16 ROM words on the switches;
// the FSM registers each play, compares it to the current word and advances.
module circuito_exp4
  import circuito_exp4_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [DATA_W-1:0] chaves,
  output logic              acertou,
  output logic              errou,
  output logic              pronto,
  output logic [DATA_W-1:0] leds,
  output logic              db_igual,
  output logic [6:0]        db_contagem,
  output logic [6:0]        db_memoria,
  output logic [6:0]        db_estado,
  output logic [6:0]        db_jogadafeita,
  output logic              db_clock,
  output logic              db_iniciar,
  output logic              db_tem_jogada
);

  estado_t           estado;
  logic [ADDR_W-1:0] contagem;
  logic [DATA_W-1:0] jogada;
  logic [DATA_W-1:0] memoria;
  logic              jogada_anterior;
  logic              tem_jogada;
  logic              igual;
  logic              fim_contagem;

  assign memoria      = rom_word(contagem);
  assign igual        = (jogada == memoria);
  assign fim_contagem = (contagem == {ADDR_W{1'b1}});

  // Gated by reset so the pulse reads 0 while reset is held, even with a
  // switch already pressed.
  assign tem_jogada = (|chaves) & ~jogada_anterior & reset;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      jogada_anterior <= 1'b0;
    end else begin
      jogada_anterior <= |chaves;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem <= '0;
    end else if (estado == PREPARACAO) begin
      contagem <= '0;
    end else if (estado == PROXIMO) begin
      contagem <= contagem + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      jogada <= '0;
    end else if (estado == PREPARACAO) begin
      jogada <= '0;
    end else if (estado == REGISTRA) begin
      jogada <= chaves;
    end
  end

  // Result flags are registered alongside the state: each branch that enters
  // (or stays in) a final state raises them, every other path clears them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado  <= INICIAL;
      acertou <= 1'b0;
      errou   <= 1'b0;
      pronto  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so the defaults below and the branch
      // overrides resolve to the last assignment without ordering races.
      acertou <= 1'b0;
      errou   <= 1'b0;
      pronto  <= 1'b0;
      case (estado)
        INICIAL:       if (iniciar) estado <= PREPARACAO;
        PREPARACAO:    estado <= ESPERA_JOGADA;
        ESPERA_JOGADA: if (tem_jogada) estado <= REGISTRA;
        REGISTRA:      estado <= COMPARA;
        COMPARA: begin
          if (!igual) begin
            estado <= FIM_ERRO;
            errou  <= 1'b1;
            pronto <= 1'b1;
          end else if (fim_contagem) begin
            estado  <= FIM_ACERTO;
            acertou <= 1'b1;
            pronto  <= 1'b1;
          end else begin
            estado <= PROXIMO;
          end
        end
        PROXIMO:       estado <= ESPERA_JOGADA;
        FIM_ACERTO: begin
          if (iniciar) begin
            estado <= PREPARACAO;
          end else begin
            acertou <= 1'b1;
            pronto  <= 1'b1;
          end
        end
        FIM_ERRO: begin
          if (iniciar) begin
            estado <= PREPARACAO;
          end else begin
            errou  <= 1'b1;
            pronto <= 1'b1;
          end
        end
        default:       estado <= INICIAL;
      endcase
    end
  end

  assign leds          = jogada;
  assign db_igual      = igual;
  assign db_clock      = clock;
  assign db_iniciar    = iniciar;
  assign db_tem_jogada = tem_jogada;

  hexa7seg u_hex_contagem (.hexa(contagem),       .display(db_contagem));
  hexa7seg u_hex_memoria  (.hexa(memoria),        .display(db_memoria));
  hexa7seg u_hex_estado   (.hexa(4'(estado)),     .display(db_estado));
  hexa7seg u_hex_jogada   (.hexa(jogada),         .display(db_jogadafeita));

endmodule

// File: tb/tb_circuito_exp4.sv
// Directed bench for circuito_exp4: full win, early loss, restart, mid-game
// reset and single-pulse play detection, with hand-computed expectations.
module tb_circuito_exp4;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] chaves;
  logic       acertou, errou, pronto;
  logic [3:0] leds;
  logic       db_igual;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita;
  logic       db_clock, db_iniciar, db_tem_jogada;

  int n_tests = 0;
  int n_fail  = 0;

  // Active-low gfedcba glyphs used as expected display codes.
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  logic [3:0] seq [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                           4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

  circuito_exp4 dut (
    .clock          (clock),
    .reset          (reset),
    .iniciar        (iniciar),
    .chaves         (chaves),
    .acertou        (acertou),
    .errou          (errou),
    .pronto         (pronto),
    .leds           (leds),
    .db_igual       (db_igual),
    .db_contagem    (db_contagem),
    .db_memoria     (db_memoria),
    .db_estado      (db_estado),
    .db_jogadafeita (db_jogadafeita),
    .db_clock       (db_clock),
    .db_iniciar     (db_iniciar),
    .db_tem_jogada  (db_tem_jogada)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    cycles(5);
    iniciar = 1'b0;
  endtask

  // Holds v for 10 cycles then 0000 for 10; counts play-detect pulses seen
  // in the low phase of each hold cycle.
  task automatic play(input logic [3:0] v, output int pulses);
    pulses = 0;
    chaves = v;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (db_tem_jogada === 1'b1) pulses++;
      @(negedge clock);
    end
    chaves = 4'h0;
    cycles(10);
  endtask

  initial begin
    int p;
    reset   = 1'b1;
    iniciar = 1'b0;
    chaves  = 4'h1;
    #2 reset = 1'b0;
    cycles(3);
    check("rst_estado",   16'(db_estado),     16'(SEG_0));
    check("rst_memoria",  16'(db_memoria),    16'(SEG_1));
    check("rst_contagem", 16'(db_contagem),   16'(SEG_0));
    check("rst_pulse",    16'(db_tem_jogada), 16'h0);
    chaves = 4'h0;
    cycles(1);
    reset = 1'b1;
    cycles(10);
    check("idle_estado", 16'(db_estado), 16'(SEG_0));
    check("idle_pronto", 16'(pronto),    16'h0);
    check("idle_leds",   16'(leds),      16'h0);

    // Full winning game; the first play also checks single-pulse detection.
    start_game();
    check("start_estado", 16'(db_estado), 16'(SEG_2));
    play(seq[0], p);
    check("one_pulse",    16'(p),            16'h1);
    check("one_incr",     16'(db_contagem),  16'(SEG_1));
    check("one_estado",   16'(db_estado),    16'(SEG_2));
    for (int i = 1; i < 16; i++) play(seq[i], p);
    check("win_acertou",  16'(acertou),      16'h1);
    check("win_pronto",   16'(pronto),       16'h1);
    check("win_errou",    16'(errou),        16'h0);
    check("win_contagem", 16'(db_contagem),  16'(SEG_F));
    check("win_estado",   16'(db_estado),    16'(SEG_A));
    check("win_leds",     16'(leds),         16'h4);

    // Restart from FIM_ACERTO: PREPARACAO after one edge, then ESPERA_JOGADA.
    iniciar = 1'b1;
    cycles(1);
    check("rs_prep",     16'(db_estado),   16'(SEG_1));
    cycles(4);
    iniciar = 1'b0;
    check("rs_estado",   16'(db_estado),   16'(SEG_2));
    check("rs_contagem", 16'(db_contagem), 16'(SEG_0));
    check("rs_acertou",  16'(acertou),     16'h0);
    check("rs_pronto",   16'(pronto),      16'h0);

    // Wrong play at address 4 (expects 0100, gets 0001).
    for (int i = 0; i < 4; i++) play(seq[i], p);
    play(4'h1, p);
    check("err_errou",   16'(errou),     16'h1);
    check("err_pronto",  16'(pronto),    16'h1);
    check("err_acertou", 16'(acertou),   16'h0);
    check("err_leds",    16'(leds),      16'h1);
    check("err_estado",  16'(db_estado), 16'(SEG_E));

    // Reset asserted mid-game with the counter at 5.
    start_game();
    for (int i = 0; i < 5; i++) play(seq[i], p);
    check("mid_contagem", 16'(db_contagem), 16'(SEG_5));
    check("mid_leds",     16'(leds),        16'h4);
    #2 reset = 1'b0;
    #1;
    check("ab_estado",   16'(db_estado),   16'(SEG_0));
    check("ab_contagem", 16'(db_contagem), 16'(SEG_0));
    check("ab_results",  16'({acertou, errou, pronto}), 16'h0);
    check("ab_leds",     16'(leds),        16'h0);
    cycles(2);
    reset = 1'b1;
    cycles(5);
    check("ab_stay",     16'(db_estado),   16'(SEG_0));
    chaves = 4'h4;
    cycles(3);
    chaves = 4'h0;
    check("ab_nogame",   16'(db_estado),   16'(SEG_0));
    check("ab_memoria",  16'(db_memoria),  16'(SEG_1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected end before 200000");
    $fatal(1);
  end

endmodule
